mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Memory-access stage. Consumes the 79-bit execute-stage result packet and performs the
//  data-memory load or store it describes. Emits a registered writeback packet to the
//  register file. Contains a DEPTH x DATA_W data RAM with a fixed MEM_LATENCY access delay,
//  and back-pressures the execute stage with a valid/ready handshake while an access is busy.
// PARAMETERS
//  ADDR_W       8    data-memory address width; also width of packet field [7:0]
//  DATA_W       64   data word width; also width of packet field [71:8]
//  DEPTH        256  number of RAM words (2**ADDR_W)
//  MEM_LATENCY  2    extra wait cycles for a load/store; 0 = same timing as an ALU-only op
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  rst        in   1   synchronous, active-high reset
//  ex_packet  in   79  [7:0] addr, [71:8] value, [72] is_load, [73] is_mem_write,
//                      [74] is_write, [78:75] dest reg
//  ex_valid   in   1   ex_packet is valid this cycle
//  ex_ready   out  1   stage can accept; handshake occurs when ex_valid & ex_ready at an edge
//  wb_packet  out  69  [63:0] writeback value, [67:64] dest reg, [68] is_write
//  wb_valid   out  1   one-cycle pulse; wb_packet is valid this cycle
// BEHAVIOUR
//  - Reset (rst=1 at an edge):
//      state<=IDLE, wb_valid<=0, wb_packet<=0, latched packet<=0, counter<=0.
//      RAM contents are NOT cleared by rst; the RAM is initialised to zero at time 0.
//  - ex_ready = (state==IDLE) & ~rst. ex_ready is combinational; it has no dependence on ex_valid.
//  - FSM states: IDLE, WAIT.
//  - IDLE, handshake at edge t0:
//      * Packet latched.
//      * If (is_load|is_mem_write) and MEM_LATENCY>0: go to WAIT with cnt<=MEM_LATENCY.
//      * Otherwise: access performed at this edge; wb_valid=1 during cycle t0+1; stay IDLE.
//        Throughput is 1 packet/cycle.
//  - WAIT: ex_ready=0, so ex_valid held high is not accepted. cnt decrements each edge.
//    At the edge where cnt==1:
//      * Access performed.
//      * wb_valid=1 in the following cycle, i.e. cycle t0+1+MEM_LATENCY.
//      * Return to IDLE; next acceptance is possible at the following edge.
//  - Access:
//      * is_mem_write: RAM[addr] <= value; wb value = value.
//      * is_load (without is_mem_write): wb value = RAM[addr].
//      * Both set: treated as a store only.
//      * Neither set: wb value = packet value.
//  - wb_packet fields:
//      * wb_packet[67:64] = dest reg; wb_packet[68] = is_write. Both pass through unchanged.
//      * wb_packet holds its last value while wb_valid=0.
//  - Address: the full 8-bit address is used; no wrap or bounds logic. 8'hFF is a legal word.
//  - Ordering: a store commits before the next packet can be accepted, so a load
//    immediately after a store to the same address returns the new data.
//  - Reset during WAIT: the access is aborted, a pending store is not committed,
//    no wb_valid pulse is produced, and the FSM goes to IDLE.
//  - wb_valid is never high in two consecutive cycles for memory ops. For back-to-back
//    ALU-only ops it may be high for consecutive cycles.
// TESTING
//  1 Reset: rst=1 for 2 edges -> wb_valid=0, wb_packet=0, ex_ready=0 during rst;
//    ex_ready=1 in the first cycle after release.
//  2 ALU pass-through: {reg=D, is_write=1, value=64'h3} -> wb_valid one cycle later with
//    wb_packet={1, 4'hD, 64'h3}; ex_ready stays 1.
//  3 Store/load (MEM_LATENCY=2):
//    store value 64'hDEADBEEF to addr 8'h20 -> ex_ready=0 for 2 cycles,
//    wb_valid at t0+3 with is_write=0;
//    then load addr 8'h20, reg 5 -> wb_valid at t0'+3 with value 64'hDEADBEEF, reg 5.
//  4 Back-to-back: three ALU-only packets on consecutive edges -> wb_valid high 3 consecutive
//    cycles with values in order.
//  5 Stall hold: ex_valid held high with a second packet during WAIT -> accepted exactly
//    once, on the first edge after returning to IDLE.
//  6 Reset mid-op: store 64'h1 to 8'hFF, assert rst during WAIT -> no wb_valid;
//    a later load of 8'hFF returns 64'h0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access stage: performs the load/store described by the execute packet
// against an internal data RAM and emits a registered writeback packet.
module mem_access_unit #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W+DATA_W+6:0] ex_packet,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  output logic [DATA_W+4:0]        wb_packet,
  output logic                     wb_valid
);

  // state | meaning
  // IDLE  | ready for a packet; ALU-only ops (and zero-latency memory ops) complete here
  // WAIT  | memory access in flight; cnt_q holds the edges left until the access edge

  localparam int PKT_W   = ADDR_W + DATA_W + 7;
  localparam int WB_W    = DATA_W + 5;
  localparam int VAL_LO  = ADDR_W;
  localparam int VAL_HI  = ADDR_W + DATA_W - 1;
  localparam int B_LD    = ADDR_W + DATA_W;
  localparam int B_MWR   = ADDR_W + DATA_W + 1;
  localparam int B_WR    = ADDR_W + DATA_W + 2;
  localparam int DEST_LO = ADDR_W + DATA_W + 3;
  localparam int DEST_HI = ADDR_W + DATA_W + 6;
  localparam int CNT_W   = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [WB_W-1:0]    wb_packet_q, wb_packet_d;
  logic               wb_valid_q, wb_valid_d;

  // 2-state storage starts at zero and is deliberately untouched by rst
  bit   [DATA_W-1:0]  mem_q [DEPTH];

  logic               hs;
  logic               do_access;
  logic [PKT_W-1:0]   acc_pkt;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_value;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  wb_value;

  assign ex_ready = (state_q == IDLE) && !rst;
  assign hs       = ex_valid && ex_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pkt_d     = pkt_q;
    do_access = 1'b0;
    acc_pkt   = ex_packet;
    case (state_q)
      IDLE: begin
        if (hs) begin
          pkt_d = ex_packet;
          if ((ex_packet[B_LD] || ex_packet[B_MWR]) && MEM_LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(MEM_LATENCY);
          end else begin
            do_access = 1'b1;
          end
        end
      end
      WAIT: begin
        acc_pkt = pkt_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          do_access = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    acc_addr  = acc_pkt[ADDR_W-1:0];
    acc_value = acc_pkt[VAL_HI:VAL_LO];
    rd_data   = mem_q[acc_addr];
    // a packet flagged both load and store behaves as a store
    if (acc_pkt[B_MWR])     wb_value = acc_value;
    else if (acc_pkt[B_LD]) wb_value = rd_data;
    else                    wb_value = acc_value;
    wb_valid_d  = do_access;
    wb_packet_d = wb_packet_q;
    if (do_access) wb_packet_d = {acc_pkt[B_WR], acc_pkt[DEST_HI:DEST_LO], wb_value};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pkt_q       <= '0;
      wb_packet_q <= '0;
      wb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pkt_q       <= pkt_d;
      wb_packet_q <= wb_packet_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  // rst aborts a store that would otherwise commit on this edge
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_pkt[B_MWR]) mem_q[acc_addr] <= acc_value;
  end

  assign wb_packet = wb_packet_q;
  assign wb_valid  = wb_valid_q;

endmodule
